// File: rtl/async_fifo_wr_ctrl.sv
// Write-side controller of a dual-clock FIFO: accepts a valid/ready stream, drives the RAM write port,
// publishes a Gray write pointer and derives full/almost_full/fill/overflow from the synced read pointer.
module async_fifo_wr_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int AF_THRESH  = 12
) (
    input  logic                  clk_w,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH:0]   rd_ptr_gray,
    output logic                  en_w,
    output logic [ADDR_WIDTH-1:0] write_addr,
    output logic [DATA_WIDTH-1:0] data,
    output logic [ADDR_WIDTH:0]   wr_ptr_gray,
    output logic                  full,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   wr_count,
    output logic                  overflow
);

    localparam int PW = ADDR_WIDTH + 1;
    localparam logic [PW-1:0] AF_LEVEL = PW'(AF_THRESH);

    logic [PW-1:0] r_wrBin;
    logic [PW-1:0] r_wrGray;
    logic [PW-1:0] r_rq1;
    logic [PW-1:0] r_rq2;
    logic          r_full;
    logic          r_almostFull;
    logic [PW-1:0] r_wrCount;
    logic          r_overflow;

    logic          w_accept;
    logic [PW-1:0] w_wrBinNext;
    logic [PW-1:0] w_wrGrayNext;
    logic [PW-1:0] w_rdBin;
    logic [PW-1:0] w_fill;
    logic [PW-1:0] w_fullPattern;

    assign in_ready     = reset & ~r_full;
    assign w_accept     = in_valid & in_ready;
    assign en_w         = w_accept;
    assign write_addr   = r_wrBin[ADDR_WIDTH-1:0];
    assign data         = in_data;

    assign w_wrBinNext  = r_wrBin + {{(PW-1){1'b0}}, w_accept};
    assign w_wrGrayNext = w_wrBinNext ^ (w_wrBinNext >> 1);

    // Each binary bit of the read pointer is the XOR of all Gray bits at or above it.
    always_comb begin
        w_rdBin = '0;
        for (int i = 0; i < PW; i++) begin
            w_rdBin[i] = ^(r_rq2 >> i);
        end
    end

    assign w_fill        = w_wrBinNext - w_rdBin;
    // Full when the write pointer is exactly one lap ahead: top two Gray bits inverted, rest equal.
    assign w_fullPattern = {~r_rq2[PW-1:PW-2], r_rq2[PW-3:0]};

    always_ff @(posedge clk_w) begin
        if (!reset) begin
            r_wrBin      <= '0;
            r_wrGray     <= '0;
            r_rq1        <= '0;
            r_rq2        <= '0;
            r_full       <= 1'b0;
            r_almostFull <= 1'b0;
            r_wrCount    <= '0;
            r_overflow   <= 1'b0;
        end else begin
            r_wrBin      <= w_wrBinNext;
            r_wrGray     <= w_wrGrayNext;
            r_rq1        <= rd_ptr_gray;
            r_rq2        <= r_rq1;
            r_full       <= (w_wrGrayNext == w_fullPattern);
            r_almostFull <= (w_fill >= AF_LEVEL);
            r_wrCount    <= w_fill;
            if (in_valid && r_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign wr_ptr_gray = r_wrGray;
    assign full        = r_full;
    assign almost_full = r_almostFull;
    assign wr_count    = r_wrCount;
    assign overflow    = r_overflow;

endmodule

// File: tb/tb_async_fifo_wr_ctrl.sv
// Scoreboard bench for async_fifo_wr_ctrl: expected RAM writes are queued by the stimulus and
// popped by a monitor whenever en_w is seen; status outputs are checked directly after each edge.
module tb_async_fifo_wr_ctrl;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int PW = AW + 1;

    logic          clk_w = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic [PW-1:0] rd_ptr_gray = '0;
    logic          in_ready;
    logic          en_w;
    logic [AW-1:0] write_addr;
    logic [DW-1:0] data;
    logic [PW-1:0] wr_ptr_gray;
    logic          full;
    logic          almost_full;
    logic [PW-1:0] wr_count;
    logic          overflow;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t expQ[$];
    int  testsRun = 0;
    int  testsFailed = 0;

    async_fifo_wr_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AF_THRESH(12)) dut (
        .clk_w       (clk_w),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .rd_ptr_gray (rd_ptr_gray),
        .en_w        (en_w),
        .write_addr  (write_addr),
        .data        (data),
        .wr_ptr_gray (wr_ptr_gray),
        .full        (full),
        .almost_full (almost_full),
        .wr_count    (wr_count),
        .overflow    (overflow)
    );

    always #5 clk_w = ~clk_w;

    function automatic logic [PW-1:0] gray(input logic [PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, optionally queue the write it should produce, then step past the edge.
    task automatic applyStimulus(input logic v, input logic [DW-1:0] d, input logic [PW-1:0] rg,
                                 input bit expWr, input logic [AW-1:0] addr);
        in_valid    = v;
        in_data     = d;
        rd_ptr_gray = rg;
        if (expWr) expQ.push_back({addr, d});
        @(posedge clk_w);
        #1;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_en_w"}, en_w, 0);
        checkOutput({tag, "_in_ready"}, in_ready, 0);
        checkOutput({tag, "_write_addr"}, write_addr, 0);
        checkOutput({tag, "_wr_ptr_gray"}, wr_ptr_gray, 0);
        checkOutput({tag, "_full"}, full, 0);
        checkOutput({tag, "_almost_full"}, almost_full, 0);
        checkOutput({tag, "_wr_count"}, wr_count, 0);
        checkOutput({tag, "_overflow"}, overflow, 0);
    endtask

    // Monitor: every RAM write seen must match the oldest expected write.
    always @(negedge clk_w) begin
        if (en_w) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_write", {20'h0, write_addr, data}, 0);
            end else begin
                wr_t e;
                e = expQ.pop_front();
                checkOutput("write_addr", write_addr, e.addr);
                checkOutput("write_data", data, e.data);
            end
        end
    end

    initial begin
        #50000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset held with a pending producer word.
        reset = 1'b0;
        repeat (3) applyStimulus(1'b1, 8'h55, '0, 1'b0, '0);
        checkAllZero("reset");

        reset = 1'b1;
        applyStimulus(1'b0, 8'h00, '0, 1'b0, '0);
        checkOutput("in_ready_after_reset", in_ready, 1);

        // Fill to 16 words with the reader parked at 0.
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 8'(i + 1), '0, 1'b1, 4'(i));
            checkOutput("fill_wr_count", wr_count, i + 1);
            checkOutput("fill_almost_full", almost_full, (i + 1) >= 12);
            checkOutput("fill_full", full, i == 15);
        end
        checkOutput("full_wr_ptr_gray", wr_ptr_gray, 5'b11000);
        checkOutput("full_in_ready", in_ready, 0);

        // Writes attempted while full are dropped and flagged.
        repeat (2) applyStimulus(1'b1, 8'hAA, '0, 1'b0, '0);
        checkOutput("ovf_en_w", en_w, 0);
        checkOutput("ovf_wr_ptr_gray", wr_ptr_gray, 5'b11000);
        checkOutput("ovf_overflow", overflow, 1);

        // Reader advances to 1: full clears only on the third edge.
        applyStimulus(1'b0, 8'h00, 5'b00001, 1'b0, '0);
        checkOutput("drain_full_e1", full, 1);
        applyStimulus(1'b0, 8'h00, 5'b00001, 1'b0, '0);
        checkOutput("drain_full_e2", full, 1);
        checkOutput("drain_overflow_sticky", overflow, 1);
        applyStimulus(1'b0, 8'h00, 5'b00001, 1'b0, '0);
        checkOutput("drain_full_e3", full, 0);
        checkOutput("drain_wr_count", wr_count, 15);
        checkOutput("drain_in_ready", in_ready, 1);
        checkOutput("drain_almost_full", almost_full, 1);

        applyStimulus(1'b1, 8'hBB, 5'b00001, 1'b1, 4'd0);
        checkOutput("refill_full", full, 1);
        checkOutput("refill_wr_count", wr_count, 16);
        checkOutput("refill_overflow", overflow, 1);

        reset = 1'b0;
        applyStimulus(1'b0, 8'h00, '0, 1'b0, '0);
        checkAllZero("reset2");
        reset = 1'b1;

        // almost_full threshold crossing in both directions.
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b1, 8'(8'h20 + i), '0, 1'b1, 4'(i));
            checkOutput("af_rise", almost_full, i == 11);
        end
        applyStimulus(1'b0, 8'h00, 5'b00001, 1'b0, '0);
        checkOutput("af_fall_e1", almost_full, 1);
        applyStimulus(1'b0, 8'h00, 5'b00001, 1'b0, '0);
        checkOutput("af_fall_e2", almost_full, 1);
        applyStimulus(1'b0, 8'h00, 5'b00001, 1'b0, '0);
        checkOutput("af_fall_e3", almost_full, 0);
        checkOutput("af_fall_wr_count", wr_count, 11);

        reset = 1'b0;
        applyStimulus(1'b0, 8'h00, '0, 1'b0, '0);
        checkAllZero("reset3");
        reset = 1'b1;

        // Wrap: 32 words with the reader trailing 4 behind.
        for (int i = 0; i < 32; i++) begin
            applyStimulus(1'b1, 8'(8'h40 + i), (i >= 4) ? gray(5'(i - 4)) : 5'b0, 1'b1, 4'(i));
            checkOutput("wrap_full", full, 0);
        end
        checkOutput("wrap_wr_ptr_gray", wr_ptr_gray, 5'b00000);
        repeat (3) applyStimulus(1'b0, 8'h00, gray(5'd27), 1'b0, '0);
        checkOutput("wrap_wr_count", wr_count, 5);
        checkOutput("wrap_full_idle", full, 0);

        // Reset asserted mid-stream.
        applyStimulus(1'b1, 8'h77, gray(5'd27), 1'b1, 4'd0);
        applyStimulus(1'b1, 8'h78, gray(5'd27), 1'b1, 4'd1);
        reset = 1'b0;
        applyStimulus(1'b1, 8'h79, '0, 1'b0, '0);
        checkAllZero("reset_mid");
        reset = 1'b1;
        applyStimulus(1'b0, 8'h00, '0, 1'b0, '0);
        checkOutput("post_reset_in_ready", in_ready, 1);

        checkOutput("scoreboard_empty", expQ.size(), 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/async_fifo_wr_ctrl.md
Name: async_fifo_wr_ctrl

Overview:
Write-side controller for a dual-clock FIFO built around the simple dual-port RAM. It runs entirely in the clk_w domain and accepts a valid/ready input stream. It drives the RAM write port (en_w, write_addr, data) and maintains a Gray-coded write pointer for the read-side controller. It synchronizes the read-side Gray pointer into clk_w to generate full, almost_full, fill level and overflow status.

Parameters:
DATA_WIDTH, 8, width of a FIFO word and the RAM data port
ADDR_WIDTH, 4, RAM address width; FIFO depth = 2**ADDR_WIDTH
AF_THRESH, 12, almost_full asserts when fill level >= AF_THRESH (range 1..2**ADDR_WIDTH)

Ports:
clk_w  input  1  write-domain clock
reset  input  1  synchronous, active-low reset
in_valid  input  1  producer has a word on in_data
in_data  input  DATA_WIDTH  producer word
in_ready  output  1  controller can accept a word this cycle
rd_ptr_gray  input  ADDR_WIDTH+1  Gray read pointer, registered in the clk_r domain
en_w  output  1  RAM write enable
write_addr  output  ADDR_WIDTH  RAM write address
data  output  DATA_WIDTH  RAM write data
wr_ptr_gray  output  ADDR_WIDTH+1  registered Gray write pointer, sent to the read side
full  output  1  registered; FIFO full as seen in clk_w
almost_full  output  1  registered; fill level >= AF_THRESH
wr_count  output  ADDR_WIDTH+1  registered; conservative fill level, 0..2**ADDR_WIDTH
overflow  output  1  sticky; a write was attempted while full

Behaviour:
- Reset (reset==0 sampled at a clk_w edge) clears the following to 0: wr_bin, wr_ptr_gray, rq1, rq2, full, almost_full, wr_count and overflow.
- While reset is low, in_ready and en_w are forced to 0.
- Internal state:
  - wr_bin: binary write pointer, ADDR_WIDTH+1 bits.
  - rq1, rq2: two-flop synchronizer for rd_ptr_gray. rq2 is the only value used downstream; rq1 is never read by logic.
- Handshake:
  - in_ready = reset & ~full (combinational from registered full).
  - A word is accepted when in_valid & in_ready.
  - in_data may change freely when in_ready is 0; dropping in_valid without acceptance is legal.
- RAM drive (combinational):
  - en_w = in_valid & in_ready.
  - write_addr = wr_bin[ADDR_WIDTH-1:0].
  - data = in_data.
  - The RAM captures the word on the same clk_w edge as the acceptance, so write latency is 0 cycles.
- Pointer update:
  - On acceptance, wr_bin_next = wr_bin + 1 (modulo 2**(ADDR_WIDTH+1)); otherwise wr_bin_next = wr_bin.
  - wr_ptr_gray <= wr_bin_next ^ (wr_bin_next >> 1).
  - Exactly one Gray bit changes per accepted word.
- Full:
  - full <= (gray(wr_bin_next) == {~rq2[MSB:MSB-1], rq2[MSB-2:0]}).
  - Full asserts on the edge that accepts the 2**ADDR_WIDTH-th unread word.
  - Full deasserts no earlier than the 3rd clk_w edge after rd_ptr_gray changes: 2 edges for the synchronizer plus 1 for the full register. This pessimism is required; full must never be late.
- Fill level:
  - wr_count <= wr_bin_next - gray2bin(rq2), modulo 2**(ADDR_WIDTH+1).
  - almost_full <= (that same value >= AF_THRESH).
- Overflow:
  - Set on any edge where reset==1 & in_valid & full.
  - The rejected word is not written and wr_bin does not move.
  - Overflow is cleared only by reset.
- Wrap-around: wr_bin wraps from 2**(ADDR_WIDTH+1)-1 to 0 with no special casing; Gray wrap is single-bit.
- Simultaneous events:
  - An accepted write and a change of rq2 on the same edge both take effect; full, almost_full and wr_count use the new wr_bin_next and the current rq2.
  - A read-side pointer update that arrives while full never causes a write in that same cycle; in_ready follows the registered full.
- Reset mid-operation:
  - The write side resets to empty immediately, and in-flight words are discarded.
  - The read side must be reset in the same window. Behaviour with a non-reset read pointer is undefined.

Test Plan:
- Reset held 3 cycles with in_valid=1 -> en_w=0, in_ready=0, every output 0; after release, in_ready=1 the next cycle.
- Write 0x01..0x10 back-to-back with rd_ptr_gray=0 -> write_addr 0..15, en_w high for 16 cycles. After the 16th edge: full=1, wr_ptr_gray=5'b11000, wr_count=16, in_ready=0.
- Continuing the full scenario, hold in_valid=1 with in_data=0xAA -> en_w=0, wr_ptr_gray unchanged, overflow=1 and stays 1 until reset.
- From full, set rd_ptr_gray=5'b00001 (read ptr 1) -> full stays 1 for 2 edges and clears on the 3rd; wr_count=15; in_ready returns to 1; the next write goes to write_addr 0.
- almost_full with AF_THRESH=12 and rd_ptr_gray=0 -> almost_full rises on the edge accepting the 12th word and falls once the synced read pointer reaches 1 (wr_count 11).
- Wrap: write 32 words while the read pointer tracks 4 behind -> wr_bin wraps to 0, wr_ptr_gray returns to 5'b00000, full never asserts. Reset asserted mid-stream -> every output 0 on the next edge.
